// File: rtl/systolic_ctrl_pkg.sv
// Shared state encoding and default sizing for the systolic array controller.
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_ROLL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int DEF_ARRAY_SIZE   = 32;
  localparam int DEF_ROWS_PER_SET = 64;
  localparam int DEF_MAX_SETS     = 4;
  localparam int DEF_ADDR_DEPTH   = 128;
  localparam int DEF_CYC_W        = 16;
  localparam int PERF_W           = 32;

endpackage

// File: rtl/systolic_wb_counter.sv
// Result row/set counter: advances on each accepted write, wraps rows into sets
// and flags the final write of the run.
module systolic_wb_counter
  import systolic_ctrl_pkg::*;
#(
  parameter int ROWS_PER_SET = DEF_ROWS_PER_SET,
  parameter int MAX_SETS     = DEF_MAX_SETS,
  localparam int RW = $clog2(ROWS_PER_SET),
  localparam int SW = $clog2(MAX_SETS),
  localparam int NW = SW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          wr_en_i,
  input  logic          wr_ready_i,
  input  logic [NW-1:0] num_sets_i,
  output logic [RW-1:0] matrix_index_o,
  output logic [SW-1:0] data_set_o,
  output logic          last_write_o
);

  logic [RW-1:0] idx_q, idx_d;
  logic [SW-1:0] set_q, set_d;
  logic          accept, last_row, last_set;

  assign accept       = wr_en_i && wr_ready_i;
  assign last_row     = (idx_q == RW'(ROWS_PER_SET - 1));
  assign last_set     = ({1'b0, set_q} == (num_sets_i - NW'(1)));
  assign last_write_o = accept && last_row && last_set;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    idx_d = idx_q;
    set_d = set_q;
    if (clear_i) begin
      idx_d = '0;
      set_d = '0;
    end else if (accept && !last_write_o) begin
      // The final write leaves row/set at their last values for the host to read.
      if (last_row) begin
        idx_d = '0;
        set_d = set_q + SW'(1);
      end else begin
        idx_d = idx_q + RW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      set_q <= '0;
    end else begin
      idx_q <= idx_d;
      set_q <= set_d;
    end
  end

  assign matrix_index_o = idx_q;
  assign data_set_o     = set_q;

endmodule

// File: rtl/systolic_controller_gen.sv
// Systolic array run controller: load, warm-up, rolling compute and write-back
// with start/done handshake, wr_ready backpressure and abort.
// Optional perf counters are enabled with `define SYSCTRL_PERF_CNT_EN.
module systolic_controller_gen
  import systolic_ctrl_pkg::*;
#(
  parameter int ARRAY_SIZE   = DEF_ARRAY_SIZE,
  parameter int ROWS_PER_SET = DEF_ROWS_PER_SET,
  parameter int MAX_SETS     = DEF_MAX_SETS,
  parameter int ADDR_DEPTH   = DEF_ADDR_DEPTH,
  parameter int CYC_W        = DEF_CYC_W,
  localparam int AW = $clog2(ADDR_DEPTH),
  localparam int RW = $clog2(ROWS_PER_SET),
  localparam int SW = $clog2(MAX_SETS),
  localparam int NW = SW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NW-1:0]    cfg_num_sets,
  input  logic             abort,
  input  logic             wr_ready,
  output logic             busy,
  output logic             alu_en,
  output logic             wr_en,
  output logic [AW-1:0]    addr_serial_num,
  output logic [CYC_W-1:0] cycle_num,
  output logic [RW-1:0]    matrix_index,
  output logic [SW-1:0]    data_set,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err
`ifdef SYSCTRL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cycles,
  output logic [PERF_W-1:0] perf_busy_cycles
`endif
);

  state_t           state_q, state_d;
  logic [NW-1:0]    sets_q, sets_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             busy_q, done_q, aborted_q, cfg_err_q;
  logic             cfg_ok, start_ok, abort_take, stall, last_write;

  assign cfg_ok     = (cfg_num_sets != '0) && (cfg_num_sets <= NW'(MAX_SETS));
  assign start_ok   = (state_q == S_IDLE) && start && cfg_ok;
  assign abort_take = abort && (state_q != S_IDLE);

  assign wr_en  = (state_q == S_ROLL) && (cyc_q >= CYC_W'(ARRAY_SIZE + 1));
  assign stall  = wr_en && !wr_ready;
  assign alu_en = (state_q == S_ROLL) && !stall;

  systolic_wb_counter #(
    .ROWS_PER_SET(ROWS_PER_SET),
    .MAX_SETS    (MAX_SETS)
  ) u_wb_counter (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (start_ok || abort_take),
    .wr_en_i       (wr_en),
    .wr_ready_i    (wr_ready),
    .num_sets_i    (sets_q),
    .matrix_index_o(matrix_index),
    .data_set_o    (data_set),
    .last_write_o  (last_write)
  );

  always_comb begin
    state_d = state_q;
    sets_d  = sets_q;
    addr_d  = addr_q;
    cyc_d   = cyc_q;
    case (state_q)
      S_IDLE: if (start_ok) begin
        state_d = S_LOAD;
        sets_d  = cfg_num_sets;
        addr_d  = '0;
        cyc_d   = '0;
      end
      S_LOAD: begin
        addr_d  = AW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        addr_d  = AW'(2);
        state_d = S_ROLL;
      end
      S_ROLL: begin
        if (!stall) begin
          if (cyc_q != '1) cyc_d = cyc_q + CYC_W'(1);
          if (addr_q != AW'(ADDR_DEPTH - 1)) addr_d = addr_q + AW'(1);
        end
        if (last_write) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort outranks completion taken in the same cycle.
    if (abort_take) begin
      state_d = S_IDLE;
      sets_d  = '0;
      addr_d  = '0;
      cyc_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sets_q    <= '0;
      addr_q    <= '0;
      cyc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sets_q    <= sets_d;
      addr_q    <= addr_d;
      cyc_q     <= cyc_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      aborted_q <= abort_take;
      cfg_err_q <= (state_q == S_IDLE) && start && !cfg_ok;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign aborted         = aborted_q;
  assign cfg_err         = cfg_err_q;
  assign addr_serial_num = addr_q;
  assign cycle_num       = cyc_q;

`ifdef SYSCTRL_PERF_CNT_EN
  logic [PERF_W-1:0] perf_stall_q, perf_busy_q;

  // The accepting cycle itself is counted as busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_busy_q  <= '0;
    end else if (start_ok) begin
      perf_stall_q <= '0;
      perf_busy_q  <= PERF_W'(1);
    end else begin
      if (stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + PERF_W'(1);
      if ((state_q != S_IDLE) && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + PERF_W'(1);
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_busy_cycles  = perf_busy_q;
`endif

endmodule

// File: tb/tb_systolic_controller_gen.sv
// Directed bench for systolic_controller_gen (ARRAY_SIZE=4, ROWS_PER_SET=8, MAX_SETS=4).
module tb_systolic_controller_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  cfg_num_sets = '0;
  logic        abort = 1'b0;
  logic        wr_ready = 1'b1;
  logic        busy, alu_en, wr_en, done, aborted, cfg_err;
  logic [6:0]  addr_serial_num;
  logic [15:0] cycle_num;
  logic [2:0]  matrix_index;
  logic [1:0]  data_set;
`ifdef SYSCTRL_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_busy_cycles;
`endif

  int checks = 0;
  int errors = 0;

  systolic_controller_gen #(
    .ARRAY_SIZE(4), .ROWS_PER_SET(8), .MAX_SETS(4), .ADDR_DEPTH(128), .CYC_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_sets(cfg_num_sets),
    .abort(abort), .wr_ready(wr_ready), .busy(busy), .alu_en(alu_en),
    .wr_en(wr_en), .addr_serial_num(addr_serial_num), .cycle_num(cycle_num),
    .matrix_index(matrix_index), .data_set(data_set), .done(done),
    .aborted(aborted), .cfg_err(cfg_err)
`ifdef SYSCTRL_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_busy_cycles(perf_busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int   cyc;
    logic rdy;
    logic busy;
    logic alu;
    logic wr;
    logic done;
    int   idx;   // -1: not compared
    int   cnum;
    int   addr;
  } vec_t;

  vec_t vt[37];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n);
    start = 1'b1;
    cfg_num_sets = 3'(n);
    tick();
    start = 1'b0;
  endtask

  initial begin
    int k;
    // Single-set run, then the same run with wr_ready low in cycles 10..12.
    vt[0]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{2, 1, 1, 0, 0, 0, 0, 0, 1};
    vt[2]  = '{3, 1, 1, 1, 0, 0, 0, 0, 2};
    vt[3]  = '{4, 1, 1, 1, 0, 0, 0, 1, 3};
    vt[4]  = '{5, 1, 1, 1, 0, 0, 0, 2, 4};
    vt[5]  = '{6, 1, 1, 1, 0, 0, 0, 3, 5};
    vt[6]  = '{7, 1, 1, 1, 0, 0, 0, 4, 6};
    vt[7]  = '{8, 1, 1, 1, 1, 0, 0, 5, 7};
    vt[8]  = '{9, 1, 1, 1, 1, 0, 1, 6, 8};
    vt[9]  = '{10, 1, 1, 1, 1, 0, 2, 7, 9};
    vt[10] = '{11, 1, 1, 1, 1, 0, 3, 8, 10};
    vt[11] = '{12, 1, 1, 1, 1, 0, 4, 9, 11};
    vt[12] = '{13, 1, 1, 1, 1, 0, 5, 10, 12};
    vt[13] = '{14, 1, 1, 1, 1, 0, 6, 11, 13};
    vt[14] = '{15, 1, 1, 1, 1, 0, 7, 12, 14};
    vt[15] = '{16, 1, 1, 0, 0, 1, -1, 13, 15};
    vt[16] = '{17, 1, 0, 0, 0, 0, -1, 13, 15};
    for (int i = 0; i < 9; i++) vt[17 + i] = vt[i];
    vt[26] = '{10, 0, 1, 0, 1, 0, 2, 7, 9};
    vt[27] = '{11, 0, 1, 0, 1, 0, 2, 7, 9};
    vt[28] = '{12, 0, 1, 0, 1, 0, 2, 7, 9};
    vt[29] = '{13, 1, 1, 1, 1, 0, 2, 7, 9};
    vt[30] = '{14, 1, 1, 1, 1, 0, 3, 8, 10};
    vt[31] = '{15, 1, 1, 1, 1, 0, 4, 9, 11};
    vt[32] = '{16, 1, 1, 1, 1, 0, 5, 10, 12};
    vt[33] = '{17, 1, 1, 1, 1, 0, 6, 11, 13};
    vt[34] = '{18, 1, 1, 1, 1, 0, 7, 12, 14};
    vt[35] = '{19, 1, 1, 0, 0, 1, -1, 13, 15};
    vt[36] = '{20, 1, 0, 0, 0, 0, -1, 13, 15};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_alu_en", alu_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_addr", addr_serial_num, 0);
    check("rst_cycle_num", cycle_num, 0);
    check("rst_matrix_index", matrix_index, 0);
    check("rst_data_set", data_set, 0);
    check("rst_pulses", {done, aborted, cfg_err}, 0);
    rst = 1'b0;
    tick();

    // Table runs
    for (int i = 0; i < 37; i++) begin
      if (vt[i].cyc == 1) begin
        wr_ready = 1'b1;
        start = 1'b1;
        cfg_num_sets = 3'd1;
      end
      tick();
      start = 1'b0;
      wr_ready = vt[i].rdy;
      #1;
      check($sformatf("v%0d_c%0d_busy", i, vt[i].cyc), busy, int'(vt[i].busy));
      check($sformatf("v%0d_c%0d_alu_en", i, vt[i].cyc), alu_en, int'(vt[i].alu));
      check($sformatf("v%0d_c%0d_wr_en", i, vt[i].cyc), wr_en, int'(vt[i].wr));
      check($sformatf("v%0d_c%0d_done", i, vt[i].cyc), done, int'(vt[i].done));
      if (vt[i].idx >= 0)
        check($sformatf("v%0d_c%0d_matrix_index", i, vt[i].cyc), matrix_index, vt[i].idx);
      check($sformatf("v%0d_c%0d_cycle_num", i, vt[i].cyc), cycle_num, vt[i].cnum);
      check($sformatf("v%0d_c%0d_addr", i, vt[i].cyc), addr_serial_num, vt[i].addr);
    end
`ifdef SYSCTRL_PERF_CNT_EN
    check("perf_stall_cycles", perf_stall_cycles, 3);
    check("perf_busy_cycles", perf_busy_cycles, 20);
    tick();
    check("perf_busy_hold", perf_busy_cycles, 20);
`endif
    wr_ready = 1'b1;
    tick();

    // Two data sets: 16 writes, set 0 -> 1 after row 7, one done pulse
    begin
      int wr_cnt, done_cyc, done_cnt, first_wr, busy25;
      int set_at[16];
      int idx_at[16];
      wr_cnt = 0; done_cyc = -1; done_cnt = 0; first_wr = -1; busy25 = -1;
      start_run(2);
      for (int c = 1; c <= 40; c++) begin
        if (wr_en && wr_ready) begin
          if (wr_cnt < 16) begin
            set_at[wr_cnt] = int'(data_set);
            idx_at[wr_cnt] = int'(matrix_index);
          end
          if (first_wr < 0) first_wr = c;
          wr_cnt++;
        end
        if (done) begin
          done_cnt++;
          if (done_cyc < 0) done_cyc = c;
        end
        if (c == 25) busy25 = int'(busy);
        tick();
      end
      check("two_set_writes", wr_cnt, 16);
      check("two_set_first_wr", first_wr, 8);
      check("two_set_done_count", done_cnt, 1);
      check("two_set_done_cycle", done_cyc, 24);
      check("two_set_busy_after", busy25, 0);
      check("two_set_w7_set", set_at[7], 0);
      check("two_set_w7_idx", idx_at[7], 7);
      check("two_set_w8_set", set_at[8], 1);
      check("two_set_w8_idx", idx_at[8], 0);
      check("two_set_w15_set", set_at[15], 1);
      check("two_set_w15_idx", idx_at[15], 7);
    end

    // Abort at cycle 9, restart at cycle 12
    begin
      int done_cyc, wr_cnt, ab_cnt;
      start_run(1);
      repeat (8) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_pulse", aborted, 1);
      check("abort_no_done", done, 0);
      check("abort_cycle_num", cycle_num, 0);
      check("abort_matrix_index", matrix_index, 0);
      check("abort_addr", addr_serial_num, 0);
      tick();
      check("abort_pulse_end", aborted, 0);
      tick();
      start_run(1);
      done_cyc = -1; wr_cnt = 0; ab_cnt = 0;
      for (int c = 13; c <= 40; c++) begin
        if (wr_en && wr_ready) wr_cnt++;
        if (done && done_cyc < 0) done_cyc = c;
        if (aborted) ab_cnt++;
        tick();
      end
      check("restart_done_cycle", done_cyc, 28);
      check("restart_writes", wr_cnt, 8);
      check("restart_no_abort", ab_cnt, 0);
    end

    // Abort coinciding with the final write wins over completion
    start_run(1);
    repeat (14) tick();
    check("abort_last_wr_en", wr_en, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_vs_done_done", done, 0);
    check("abort_vs_done_aborted", aborted, 1);
    check("abort_vs_done_busy", busy, 0);
    tick();

    // Abort in IDLE has no effect
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_pulse", aborted, 0);

    // Rejected configurations and the MAX_SETS boundary
    for (k = 0; k < 2; k++) begin
      start_run(k == 0 ? 0 : 5);
      check($sformatf("cfg_err_%0d", k), cfg_err, 1);
      check($sformatf("cfg_err_busy_%0d", k), busy, 0);
      tick();
      check($sformatf("cfg_err_end_%0d", k), cfg_err, 0);
    end
    start_run(4);
    check("cfg_max_accept_busy", busy, 1);
    check("cfg_max_no_err", cfg_err, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // Asynchronous reset during ROLL
    start_run(1);
    repeat (8) tick();
    check("pre_rst_wr_en", wr_en, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_alu_en", alu_en, 0);
    check("arst_wr_en", wr_en, 0);
    check("arst_cycle_num", cycle_num, 0);
    check("arst_matrix_index", matrix_index, 0);
    check("arst_addr", addr_serial_num, 0);
    #2 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post_rst_pulses_%0d", c), {done, aborted, busy}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_controller_gen.md
Name: systolic_controller_gen

Overview:
- Parametrised next-generation controller for the systolic matrix-multiply array.
- Sequences operand load, array warm-up, rolling compute and result write-back for a runtime-selected number of data sets.
- Adds a start/busy/done handshake, result-write backpressure (wr_ready), abort, and configuration error reporting.
- Sits between the TPU top-level control and the array/SRAM address and write-enable logic.

Parameters:
- ARRAY_SIZE, 32, PE rows/cols; write-back starts once cycle_num >= ARRAY_SIZE+1.
- ROWS_PER_SET, 64, result rows written per data set.
- MAX_SETS, 4, maximum data sets per run.
- ADDR_DEPTH, 128, operand address range; addr saturates at ADDR_DEPTH-1.
- CYC_W, 16, cycle_num width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request, sampled in IDLE only.
- cfg_num_sets  in  $clog2(MAX_SETS)+1  number of data sets for this run, latched at accept.
- abort  in  1  synchronous abort of the current run.
- wr_ready  in  1  result SRAM can accept a write this cycle.
- busy  out  1  high in every state except IDLE.
- alu_en  out  1  array shift/multiply enable.
- wr_en  out  1  result write valid.
- addr_serial_num  out  $clog2(ADDR_DEPTH)  operand address selector.
- cycle_num  out  CYC_W  rolling-cycle counter.
- matrix_index  out  $clog2(ROWS_PER_SET)  result row index.
- data_set  out  $clog2(MAX_SETS)  current data set.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse when an abort is taken.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; all counters, addr and pulse outputs are 0; busy/alu_en/wr_en are 0.
- States: IDLE, LOAD, WAIT, ROLL, DONE.
- IDLE, start=1, cfg_num_sets in 1..MAX_SETS: latch cfg_num_sets, go to LOAD, addr=0, counters cleared.
- IDLE, start=1, cfg_num_sets=0 or >MAX_SETS: stay in IDLE, cfg_err=1 for one cycle.
- start is ignored outside IDLE.
- LOAD: addr set to 1, go to WAIT. WAIT: addr set to 2, go to ROLL.
- ROLL, not stalled:
  - alu_en=1 and cycle_num increments.
  - addr increments, saturating at ADDR_DEPTH-1.
- wr_en=1 in ROLL whenever cycle_num >= ARRAY_SIZE+1, whether or not stalled.
- Stall: wr_en=1 and wr_ready=0.
  - alu_en=0 (combinational from wr_ready).
  - cycle_num, addr, matrix_index and data_set all hold.
  - wr_en stays high (valid/ready: a row is never dropped).
- Accepted write (wr_en and wr_ready):
  - matrix_index increments.
  - At ROWS_PER_SET-1, matrix_index wraps to 0 and data_set increments.
- Completion: an accepted write at matrix_index=ROWS_PER_SET-1 with data_set=latched_sets-1 moves ROLL to DONE.
- DONE: done=1, busy=1, alu_en=0, wr_en=0; then IDLE next cycle. Counters hold their final values until the next accepted start.
- Abort: abort=1 in LOAD/WAIT/ROLL/DONE moves to IDLE next cycle with aborted=1 and done=0; counters cleared.
  - Abort has priority over completion in the same cycle.
  - abort in IDLE has no effect.
- Reset mid-run: immediate return to the reset values above; no done or aborted pulse.
- Output timing: alu_en and wr_en are decoded from registered state/counters, gated by wr_ready only as stated above. All other outputs are registered.
- Counter width: cycle_num saturates at all-ones and never wraps.

Optional Feature:
- Macro: SYSCTRL_PERF_CNT_EN.
- When defined, adds outputs perf_stall_cycles (32) and perf_busy_cycles (32).
  - Both are cleared on each accepted start.
  - They count stall cycles and busy cycles respectively, saturating, and hold after completion.
- When undefined, these ports and the counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Package systolic_ctrl_pkg:
  - state encoding constants (IDLE=0, LOAD=1, WAIT=2, ROLL=3, DONE=4, 3-bit).
  - width helper constants derived from the parameters.
- One natural sub-module: systolic_wb_counter, the row/set counter with wr_ready handshake, wrap and last-row detection.

Test Plan (ARRAY_SIZE=4, ROWS_PER_SET=8, MAX_SETS=4):
- start at cycle 0, cfg_num_sets=1, wr_ready=1 -> LOAD@1, WAIT@2, ROLL@3; wr_en cycles 8..15 with matrix_index 0..7; done=1 @16; busy=0 @17.
- cfg_num_sets=2, wr_ready=1 -> 16 writes; data_set 0->1 after matrix_index=7; single done pulse after the 16th write.
- wr_ready=0 for cycles 10..12 in the single-set run -> wr_en held high, matrix_index/cycle_num frozen, alu_en=0; done shifts to cycle 19.
- abort at cycle 9 -> IDLE @10, aborted=1 for 1 cycle, no done; a new start at cycle 12 runs cleanly.
- start with cfg_num_sets=0, then 5 -> cfg_err pulse each time, busy stays 0; rst pulse during ROLL -> all outputs 0 asynchronously.
- With SYSCTRL_PERF_CNT_EN, rerun the stall scenario -> perf_stall_cycles=3, perf_busy_cycles=20.
